// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Byte serializer that sits on the read port of an 8-deep FIFO, in the read
// clock domain. It pops one byte at a time and sends it as an 8N1 frame:
// one start bit (0), eight data bits LSB first, and one stop bit (1). Each
// bit lasts CLKS_PER_BIT clocks.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit, legal range 2..65535
//
// Ports:
//   rd_clk      in   clock; all state updates on the rising edge
//   reset       in   asynchronous, active-low reset
//   tx_enable   in   allows a new frame to start (sampled only in IDLE)
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  pop request, high only in the POP state
//   tx          out  registered serial line, idles high
//   busy        out  high whenever the state is not IDLE
//   tx_done     out  one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       rd_clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_reg_next;
  logic             tx_next;
  logic             tx_done_next;
  logic             baud_tc;
  logic             timed_state;

  assign baud_tc     = (baud_cnt == CNT_MAX);
  assign timed_state = (state == START) || (state == DATA) || (state == STOP);

  // Pop request and busy are pure decodes of the state register, so a reset
  // drops them immediately along with the state.
  assign fifo_rd_en = (state == POP);
  assign busy       = (state != IDLE);

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_reg_next;
      tx        <= tx_next;
      tx_done   <= tx_done_next;
    end
  end

  always_comb begin
    state_next     = state;
    shift_reg_next = shift_reg;
    bit_idx_next   = bit_idx;
    tx_done_next   = 1'b0;
    baud_cnt_next  = '0;
    tx_next        = 1'b1;

    case (state)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_next = POP;
        end
      end
      POP: begin
        state_next = LOAD;
      end
      LOAD: begin
        // The FIFO output register holds the popped byte during this cycle.
        shift_reg_next = fifo_data;
        state_next     = START;
      end
      START: begin
        if (baud_tc) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
        end
      end
      DATA: begin
        if (baud_tc) begin
          shift_reg_next = {1'b0, shift_reg[7:1]};
          bit_idx_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (baud_tc) begin
          state_next   = IDLE;
          tx_done_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The baud counter restarts on every state entry and wraps at terminal
    // count, so each bit inside DATA also starts from zero.
    if ((state_next != state) || baud_tc || !timed_state) begin
      baud_cnt_next = '0;
    end else begin
      baud_cnt_next = baud_cnt + 1'b1;
    end

    // tx is registered, so it is computed from the state and shift register
    // that will be live during the next cycle.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Self-checking bench for fifo_uart_tx. Two instances are used: one with
// CLKS_PER_BIT=4 and one with the minimum divider of 2. Each instance has a
// small FIFO model with a registered data_out. Single-frame cases come from a
// vector table; back-to-back, tx_enable gating and mid-frame reset are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: CLKS_PER_BIT = 4
  logic       en4 = 1'b0;
  logic       empty4;
  logic [7:0] data4 = 8'h00;
  logic       rd4, tx4, busy4, done4;

  // Instance 1: CLKS_PER_BIT = 2
  logic       en2 = 1'b0;
  logic       empty2;
  logic [7:0] data2 = 8'h00;
  logic       rd2, tx2, busy2, done2;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .rd_clk     (clk),
    .reset      (reset_n),
    .tx_enable  (en4),
    .fifo_empty (empty4),
    .fifo_data  (data4),
    .fifo_rd_en (rd4),
    .tx         (tx4),
    .busy       (busy4),
    .tx_done    (done4)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .rd_clk     (clk),
    .reset      (reset_n),
    .tx_enable  (en2),
    .fifo_empty (empty2),
    .fifo_data  (data2),
    .fifo_rd_en (rd2),
    .tx         (tx2),
    .busy       (busy2),
    .tx_done    (done2)
  );

  // FIFO models: write pointer owned by the stimulus, read pointer and
  // registered data_out owned by the clocked process.
  logic [7:0] mem4 [0:31];
  logic [7:0] mem2 [0:31];
  int wp4 = 0, rp4 = 0, pops4 = 0;
  int wp2 = 0, rp2 = 0, pops2 = 0;

  assign empty4 = (wp4 == rp4);
  assign empty2 = (wp2 == rp2);

  always @(posedge clk) begin
    if (rd4) begin
      pops4 <= pops4 + 1;
      if (wp4 != rp4) begin
        data4 <= mem4[rp4];
        rp4   <= rp4 + 1;
      end
    end
    if (rd2) begin
      pops2 <= pops2 + 1;
      if (wp2 != rp2) begin
        data2 <= mem2[rp2];
        rp2   <= rp2 + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic g_tx(input int s);
    return (s != 0) ? tx2 : tx4;
  endfunction
  function automatic logic g_busy(input int s);
    return (s != 0) ? busy2 : busy4;
  endfunction
  function automatic logic g_done(input int s);
    return (s != 0) ? done2 : done4;
  endfunction
  function automatic logic g_rd(input int s);
    return (s != 0) ? rd2 : rd4;
  endfunction
  function automatic int g_pops(input int s);
    return (s != 0) ? pops2 : pops4;
  endfunction

  task automatic set_en(input int s, input logic v);
    if (s != 0) en2 = v;
    else        en4 = v;
  endtask

  task automatic push(input int s, input logic [7:0] d);
    if (s != 0) begin
      mem2[wp2] = d;
      wp2 = wp2 + 1;
    end else begin
      mem4[wp4] = d;
      wp4 = wp4 + 1;
    end
  endtask

  // One complete frame from an idle DUT. The start condition is set up at a
  // falling edge, so the following rising edge is E; the negedge after that
  // lies in cycle E+1 (POP), then E+2 (LOAD), then the line from E+3.
  task automatic run_frame(input int s, input logic [7:0] d, input logic [0:9] line,
                           input bit do_push, input string tag);
    int n;
    int p0;
    n = (s != 0) ? 2 : 4;
    @(negedge clk);
    if (do_push) push(s, d);
    set_en(s, 1'b1);
    p0 = g_pops(s);
    @(negedge clk);
    check1({tag, " POP rd_en"}, g_rd(s), 1'b1);
    check1({tag, " POP busy"}, g_busy(s), 1'b1);
    check1({tag, " POP tx"}, g_tx(s), 1'b1);
    @(negedge clk);
    check1({tag, " LOAD rd_en"}, g_rd(s), 1'b0);
    check1({tag, " LOAD tx"}, g_tx(s), 1'b1);
    for (int k = 0; k < 10 * n; k++) begin
      @(negedge clk);
      check1($sformatf("%s tx cycle %0d", tag, k), g_tx(s), line[k / n]);
      if (k == 10 * n - 1) begin
        check1({tag, " busy in last STOP cycle"}, g_busy(s), 1'b1);
        check1({tag, " tx_done before end"}, g_done(s), 1'b0);
      end
    end
    @(negedge clk);
    check1({tag, " tx_done pulse"}, g_done(s), 1'b1);
    check1({tag, " busy after frame"}, g_busy(s), 1'b0);
    check1({tag, " tx idle"}, g_tx(s), 1'b1);
    set_en(s, 1'b0);
    @(negedge clk);
    check1({tag, " tx_done cleared"}, g_done(s), 1'b0);
    checki({tag, " pops per frame"}, g_pops(s) - p0, 1);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [0:9] line;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   p0;
    int   fall2;
    int   got;
    logic [0:9] la;
    logic [0:9] lb;
    logic exp_tx;

    // Line patterns: start bit, data LSB first, stop bit.
    vecs[0] = '{sel: 0, data: 8'hA5, line: 10'b0101001011};
    vecs[1] = '{sel: 0, data: 8'h01, line: 10'b0100000001};
    vecs[2] = '{sel: 0, data: 8'h80, line: 10'b0000000011};
    vecs[3] = '{sel: 0, data: 8'h3C, line: 10'b0001111001};
    vecs[4] = '{sel: 1, data: 8'h3C, line: 10'b0001111001};

    // Reset held, then released into an empty FIFO with tx_enable high.
    repeat (3) @(negedge clk);
    check1("reset tx4", tx4, 1'b1);
    check1("reset rd4", rd4, 1'b0);
    check1("reset busy4", busy4, 1'b0);
    check1("reset done4", done4, 1'b0);
    check1("reset tx2", tx2, 1'b1);
    check1("reset rd2", rd2, 1'b0);
    check1("reset busy2", busy2, 1'b0);
    check1("reset done2", done2, 1'b0);
    en4 = 1'b1;
    en2 = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check1($sformatf("idle tx4 cycle %0d", i), tx4, 1'b1);
      check1($sformatf("idle busy4 cycle %0d", i), busy4, 1'b0);
    end
    checki("idle pops4", pops4, 0);
    checki("idle pops2", pops2, 0);
    check1("idle tx2", tx2, 1'b1);
    en4 = 1'b0;
    en2 = 1'b0;

    // Table-driven single frames.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].line, 1'b1, $sformatf("vec%0d", i));
    end

    // Back-to-back 0x00 then 0xFF.
    la = 10'b0000000001;
    lb = 10'b0111111111;
    @(negedge clk);
    push(0, 8'h00);
    push(0, 8'hFF);
    en4 = 1'b1;
    p0 = pops4;
    @(negedge clk);
    check1("b2b first POP", rd4, 1'b1);
    @(negedge clk);
    check1("b2b first LOAD", rd4, 1'b0);
    fall2 = -1;
    for (int t = 0; t < 83; t++) begin
      @(negedge clk);
      if (t < 40)      exp_tx = la[t / 4];
      else if (t < 43) exp_tx = 1'b1;
      else             exp_tx = lb[(t - 43) / 4];
      check1($sformatf("b2b tx t=%0d", t), tx4, exp_tx);
      if (t == 40) check1("b2b done between frames", done4, 1'b1);
      if (t == 41) check1("b2b second POP", rd4, 1'b1);
      if (t >= 40 && fall2 < 0 && tx4 == 1'b0) fall2 = t;
    end
    en4 = 1'b0;
    checki("b2b start edge spacing", fall2, 43);
    checki("b2b pops", pops4 - p0, 2);
    @(negedge clk);
    check1("b2b final done", done4, 1'b1);
    check1("b2b final busy", busy4, 1'b0);

    // tx_enable gating: no pop while disabled; dropping it mid-frame lets
    // the frame finish without a further pop.
    @(negedge clk);
    push(0, 8'h5A);
    push(0, 8'hC3);
    p0 = pops4;
    repeat (20) @(negedge clk);
    checki("gate disabled pops", pops4 - p0, 0);
    check1("gate disabled busy", busy4, 1'b0);
    check1("gate disabled tx", tx4, 1'b1);
    en4 = 1'b1;
    @(negedge clk);
    check1("gate POP", rd4, 1'b1);
    repeat (8) @(negedge clk);
    check1("gate busy mid DATA", busy4, 1'b1);
    en4 = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done4) begin
        got = 1;
        break;
      end
    end
    checki("gate frame completed", got, 1);
    repeat (10) @(negedge clk);
    checki("gate pops", pops4 - p0, 1);
    check1("gate busy after", busy4, 1'b0);

    // Reset during DATA bit 3 of 0xC3, then the next byte 0x96 must follow.
    @(negedge clk);
    push(0, 8'h96);
    en4 = 1'b1;
    repeat (20) @(negedge clk);
    check1("abort tx before reset", tx4, 1'b0);
    check1("abort busy before reset", busy4, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check1("abort tx immediate", tx4, 1'b1);
    check1("abort busy immediate", busy4, 1'b0);
    check1("abort rd_en immediate", rd4, 1'b0);
    check1("abort done immediate", done4, 1'b0);
    en4 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_frame(0, 8'h96, 10'b0011010011, 1'b0, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Byte serializer that sits directly downstream of the 8-deep FIFO's read port, in the read-clock domain. It pops one byte at a time from the FIFO and transmits it on a single-wire asynchronous serial line as an 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit. Bit period is a fixed number of clocks set by parameter. It drives the FIFO's `rd_en` and consumes its `empty` flag and registered `data_out`.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit; legal range 2..65535.
- `rd_clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. 0 forces the reset state immediately, with no clock needed.
- `tx_enable` input 1: allows a new frame to start; sampled only in IDLE.
- `fifo_empty` input 1: FIFO `empty` flag.
- `fifo_data` input 8: FIFO `data_out`, registered in the FIFO and valid the cycle after `rd_en` is sampled high.
- `fifo_rd_en` output 1: pop request to the FIFO.
- `tx` output 1: serial line, idle high, registered.
- `busy` output 1: high whenever state is not IDLE.
- `tx_done` output 1: one-cycle pulse after each completed frame.

## Operation
- States: IDLE, POP, LOAD, START, DATA, STOP.
- **IDLE**
  - `tx`=1.
  - If `tx_enable`=1 and `fifo_empty`=0, go to POP; otherwise stay.
- **POP** (exactly 1 cycle)
  - `fifo_rd_en`=1, decoded from state, high only in POP.
  - `tx`=1. Next state is LOAD.
- **LOAD** (exactly 1 cycle)
  - `fifo_data` is valid. Capture it into an 8-bit shift register at the closing edge.
  - `tx`=1. Next state is START.
- **START**
  - `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA**
  - `tx` = shift register bit 0, held for `CLKS_PER_BIT` cycles per bit.
  - After each bit, shift right by 1 and increment the bit index.
  - After bit index 7, go to STOP.
- **STOP**
  - `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Baud counter**
  - Counts 0..`CLKS_PER_BIT`-1, width ceil(log2(`CLKS_PER_BIT`)).
  - Cleared on every state entry. The terminal count advances the bit or state.
- **Bit index**: 3 bits, cleared on entry to DATA.
- **tx_done**: registered. Set at the edge that ends the last STOP cycle, so it is high during the first IDLE cycle after the frame. Cleared the next cycle.
- **Mid-frame inputs**
  - `tx_enable` falling mid-frame has no effect; the current frame completes.
  - `fifo_empty` is ignored outside IDLE.
- **Reset** (including mid-frame)
  - State returns to IDLE immediately.
  - `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0.
  - Counters and shift register are cleared to 0.
  - Any partially sent byte is discarded and never retransmitted.
- Exactly one `fifo_rd_en` pulse per frame. No pop is issued while `fifo_empty`=1 is sampled in IDLE.

## Timing
- **Reset values**: `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0.
- **Start latency**: let edge E be the edge where IDLE sees a valid start condition.
  - POP runs in cycle E+1 and LOAD in E+2.
  - `tx` falls to 0 in cycle E+3.
- **Frame length**: the `tx`-low start bit through the end of the stop bit is 10×`CLKS_PER_BIT` cycles.
- **Back-to-back frames** (FIFO stays non-empty, `tx_enable`=1):
  - Falling edges of consecutive start bits are 10×`CLKS_PER_BIT`+3 cycles apart.
  - The 3 extra cycles are IDLE, POP and LOAD, all with `tx`=1.
- **busy** rises in the POP cycle and falls in the first IDLE cycle, which is the same cycle `tx_done` is high.

## Test plan
- **Reset/idle**: hold `reset`=0, then release with `fifo_empty`=1 and `tx_enable`=1 for 100 cycles → `tx`=1, `busy`=0, `fifo_rd_en` never high.
- **Single byte 0xA5, `CLKS_PER_BIT`=4**:
  - `fifo_rd_en` pulses exactly once.
  - `tx` emits 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles, starting 3 cycles after IDLE samples the start condition.
  - `tx_done` pulses once, 40 cycles after `tx` falls.
- **Back-to-back 0x00 then 0xFF** (FIFO non-empty for both):
  - Two pops.
  - Start-bit falling edges 43 cycles apart.
  - Line pattern: 0×9 bits then 1; then 0, 1×9 bits.
- **tx_enable gating**:
  - `tx_enable`=0 with a non-empty FIFO → no pop.
  - Raise `tx_enable`, then drop it mid-DATA → the frame completes and no second pop occurs.
- **Reset mid-frame**:
  - Assert `reset`=0 asynchronously during DATA bit 3 → `tx`=1 and `busy`=0 immediately, without a clock edge.
  - After release, the next frame carries the next FIFO byte, not the aborted one.
- **Minimum divider `CLKS_PER_BIT`=2, byte 0x3C**: each bit lasts 2 cycles, frame is 20 cycles, data bits LSB first are 0,0,1,1,1,1,0,0.
